uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//   UART receive sequencer driven by the 16x-oversampling Tick from the baud tick generator.
//   Detects start bit, samples each bit at its midpoint, checks stop bit, and holds the received byte
//   in a one-entry output register with a valid/ready handshake to the command decoder.
//   Sits between the Bluetooth module's TX pin and the hovercraft control logic.
// PARAMETERS
//   DATA_BITS   8    data bits per frame, LSB first (legal 5..8)
//   OVERSAMPLE  16   Tick pulses per bit period (must match tick generator setting)
// PORTS
//   Clk          in   1          system clock, 100 MHz
//   Rst_n        in   1          synchronous reset, active-low
//   Tick         in   1          one-Clk pulse at OVERSAMPLE x baud
//   Rx           in   1          asynchronous serial input, idle high
//   Rx_Data      out  DATA_BITS  received byte; stable while Rx_Valid=1
//   Rx_Valid     out  1          byte available
//   Rx_Ready     in   1          consumer accepts byte when Rx_Valid&&Rx_Ready
//   Frame_Err    out  1          1-Clk pulse: stop bit sampled low
//   Overrun_Err  out  1          1-Clk pulse: frame completed while holding reg full and not drained
//   Busy         out  1          high whenever FSM not in IDLE
// BEHAVIOUR
//   - Reset: Rx_Data=0, Rx_Valid=0, Frame_Err=0, Overrun_Err=0, Busy=0, FSM=IDLE, tick cnt=0.
//     Reset mid-frame aborts the frame; partial byte discarded, sync flops preset to 1.
//   - Rx passes 2-flop synchronizer (rx_s); adds 2 Clk latency. All decisions use rx_s.
//   - Tick counter sc (log2 OVERSAMPLE bits) advances only on Tick; cleared on every state change.
//   - IDLE: rx_s==0 -> START, sc=0. No Tick needed to leave IDLE.
//   - START: on Tick with sc==OVERSAMPLE/2-1: rx_s==0 -> DATA (sc=0, bit idx=0); rx_s==1 -> IDLE
//     (glitch rejected, no error).
//   - DATA: on Tick with sc==OVERSAMPLE-1: shift rx_s into MSB of shift reg (LSB-first), sc=0, idx++;
//     after bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
//   - STOP: on Tick with sc==OVERSAMPLE-1 sample: 1 -> deliver byte, 0 -> Frame_Err pulse, byte dropped.
//     Either way -> IDLE same cycle (mid-stop return allows back-to-back frames).
//   - Deliver: if Rx_Valid==0, or Rx_Valid&&Rx_Ready same cycle: Rx_Data<=byte, Rx_Valid<=1.
//     Else Overrun_Err pulse; new byte dropped, held byte kept.
//   - Handshake: Rx_Valid falls cycle after Rx_Valid&&Rx_Ready unless same-cycle delivery refills it.
//     Rx_Data never changes while Rx_Valid=1 and not accepted.
//   - Frame_Err and Overrun_Err never both assert for one frame (framing error wins).
//   - Tick absent: FSM holds state indefinitely; handshake still operates.
// CONFIGURATION
//   PARITY_CHECK_EN defined: extra PARITY state after DATA, one bit period, even parity.
//     Mismatch -> Par_Err output (1-Clk pulse at STOP sample), byte dropped, no Rx_Valid.
//     Par_Err port exists only when defined.
//   PARITY_CHECK_EN undefined: frame is start+DATA_BITS+stop; no PARITY state, no Par_Err port.
// STRUCTURE
//   uart_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP}, UART_OVERSAMPLE=16, UART_MID=7.
//   Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1, shared with future TX loopback.
//   Tick generator instanced alongside at top level, not inside this block.
// TESTING (bench drives Tick every 4th Clk; 1 bit = 64 Clk)
//   1 Rx frame 0xA5, Rx_Ready=1 -> Rx_Valid 1 Clk, Rx_Data=0xA5, no error pulses.
//   2 Rx low pulse of 20 Clk then high -> FSM back to IDLE, Rx_Valid=0, Frame_Err=0.
//   3 Frame 0x3C with stop bit low -> Frame_Err pulse once, Rx_Valid stays 0.
//   4 Rx_Ready=0, frames 0x11 then 0x22 -> Rx_Data=0x11 held, Overrun_Err pulse at 2nd stop.
//   5 Rx_Ready pulsed on exact 2nd-frame delivery cycle -> Rx_Valid stays 1, Rx_Data=0x22, no overrun.
//   6 Rst_n=0 mid DATA of 0x5A, then frame 0x81 -> only 0x81 delivered; with PARITY_CHECK_EN,
//     0x81 with odd parity bit -> Par_Err pulse, no Rx_Valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Optional feature macro: PARITY_CHECK_EN (adds the PARITY state and Par_Err port).
package uart_pkg;

   // Receive sequencer states; encodings are fixed so that legacy code
   // that compares raw state bits keeps working.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   // Tick pulses per bit period; must match the baud tick generator.
   localparam int UART_OVERSAMPLE = 16;

   // Tick count at which the middle of the start bit is reached.
   localparam int UART_MID = UART_OVERSAMPLE / 2 - 1;

   // Default number of data bits per frame.
   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous serial line.
// Resets to the idle (mark) level so a reset never looks like a start bit.
// Shared with the planned TX loopback path.
// Optional feature macro: PARITY_CHECK_EN (not used in this file).
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b1
)(
   input  logic Clk,
   input  logic Rst_n,
   input  logic D,
   output logic Q
);

   logic [STAGES-1:0] stage_reg;
   logic [STAGES-1:0] stage_next;

   // Stage 0 captures the raw line, every later stage copies its predecessor.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
         assign stage_next[gi] = D;
      end else begin : g_rest
         assign stage_next[gi] = stage_reg[gi-1];
      end
   end

   // Shift the line through the chain; reset presets every stage to idle.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         stage_reg <= {STAGES{RESET_VAL}};
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign Q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer clocked by a 16x oversampling Tick.
// Finds the start bit, samples every bit at its midpoint, checks the stop
// bit and parks the byte in a one-entry holding register with a
// valid/ready handshake towards the command decoder.
// Optional feature macro: PARITY_CHECK_EN -- adds an even-parity bit after
// the data bits, a PARITY state and the Par_Err output port.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
)(
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Tick,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Rx_Valid,
   input  logic                 Rx_Ready,
   output logic                 Frame_Err,
   output logic                 Overrun_Err,
`ifdef PARITY_CHECK_EN
   output logic                 Par_Err,
`endif
   output logic                 Busy
);

   // Raw state encodings, kept as plain constants for legacy compatibility.
   localparam logic [2:0] ST_IDLE   = 3'(IDLE);
   localparam logic [2:0] ST_START  = 3'(START);
   localparam logic [2:0] ST_DATA   = 3'(DATA);
`ifdef PARITY_CHECK_EN
   localparam logic [2:0] ST_PARITY = 3'(PARITY);
`endif
   localparam logic [2:0] ST_STOP   = 3'(STOP);

   localparam int SC_W  = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Start bit is re-checked half a bit in; every later bit is a full period apart.
   localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;

   logic [2:0]           state_reg,     state_next;
   logic [SC_W-1:0]      sc_reg,        sc_next;
   logic [IDX_W-1:0]     idx_reg,       idx_next;
   logic [DATA_BITS-1:0] shift_reg,     shift_next;
   logic [DATA_BITS-1:0] data_reg,      data_next;
   logic                 valid_reg,     valid_next;
   logic                 frame_err_reg, frame_err_next;
   logic                 overrun_reg,   overrun_next;
`ifdef PARITY_CHECK_EN
   logic                 par_bad_reg,   par_bad_next;
   logic                 par_err_reg,   par_err_next;
`endif

   // All decisions use the synchronized line; the raw pin is never looked at.
   uart_rx_sync #(
      .STAGES    (2),
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .D     (Rx),
      .Q     (rx_s)
   );

   // Next-state logic for the frame sequencer and the holding register.
   always_comb begin
      state_next     = state_reg;
      sc_next        = sc_reg;
      idx_next       = idx_reg;
      shift_next     = shift_reg;
      data_next      = data_reg;
      valid_next     = valid_reg;
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad_next   = par_bad_reg;
      par_err_next   = 1'b0;
`endif

      // Consumer drains the holding register; a delivery below may refill it.
      if (valid_reg && Rx_Ready) begin
         valid_next = 1'b0;
      end

      case (state_reg)
         ST_IDLE: begin
            // Leaving idle needs no Tick: the falling edge itself starts timing.
            if (!rx_s) begin
               state_next = ST_START;
               sc_next    = '0;
            end
         end

         ST_START: begin
            if (Tick) begin
               if (sc_reg == SC_MID) begin
                  sc_next = '0;
                  if (!rx_s) begin
                     state_next = ST_DATA;
                     idx_next   = '0;
                  end else begin
                     // Line already back high at mid start bit: a glitch, not a frame.
                     state_next = ST_IDLE;
                  end
               end else begin
                  sc_next = sc_reg + SC_W'(1);
               end
            end
         end

         ST_DATA: begin
            if (Tick) begin
               if (sc_reg == SC_LAST) begin
                  sc_next    = '0;
                  // LSB arrives first, so each new bit enters at the top.
                  shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                  idx_next   = idx_reg + IDX_W'(1);
                  if (idx_reg == IDX_LAST) begin
`ifdef PARITY_CHECK_EN
                     state_next = ST_PARITY;
`else
                     state_next = ST_STOP;
`endif
                  end
               end else begin
                  sc_next = sc_reg + SC_W'(1);
               end
            end
         end

`ifdef PARITY_CHECK_EN
         ST_PARITY: begin
            if (Tick) begin
               if (sc_reg == SC_LAST) begin
                  sc_next      = '0;
                  // Even parity: data ones plus the parity bit must be even.
                  par_bad_next = (^shift_reg) ^ rx_s;
                  state_next   = ST_STOP;
               end else begin
                  sc_next = sc_reg + SC_W'(1);
               end
            end
         end
`endif

         ST_STOP: begin
            if (Tick) begin
               if (sc_reg == SC_LAST) begin
                  // Return to idle at mid stop bit so a following start bit is not missed.
                  sc_next    = '0;
                  state_next = ST_IDLE;
                  if (!rx_s) begin
                     // Framing error takes precedence; the byte is never offered.
                     frame_err_next = 1'b1;
`ifdef PARITY_CHECK_EN
                  end else if (par_bad_reg) begin
                     par_err_next = 1'b1;
`endif
                  end else if (!valid_reg || Rx_Ready) begin
                     data_next  = shift_reg;
                     valid_next = 1'b1;
                  end else begin
                     // Holding register still full: keep the old byte, drop the new one.
                     overrun_next = 1'b1;
                  end
               end else begin
                  sc_next = sc_reg + SC_W'(1);
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            sc_next    = '0;
         end
      endcase
   end

   // Sequencer registers; reset abandons any partial frame.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg   <= ST_IDLE;
         sc_reg      <= '0;
         idx_reg     <= '0;
         shift_reg   <= '0;
`ifdef PARITY_CHECK_EN
         par_bad_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         sc_reg      <= sc_next;
         idx_reg     <= idx_next;
         shift_reg   <= shift_next;
`ifdef PARITY_CHECK_EN
         par_bad_reg <= par_bad_next;
`endif
      end
   end

   // Holding register, handshake flag and single-cycle error pulses.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_err_reg   <= 1'b0;
`endif
      end else begin
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         frame_err_reg <= frame_err_next;
         overrun_reg   <= overrun_next;
`ifdef PARITY_CHECK_EN
         par_err_reg   <= par_err_next;
`endif
      end
   end

   assign Rx_Data     = data_reg;
   assign Rx_Valid    = valid_reg;
   assign Frame_Err   = frame_err_reg;
   assign Overrun_Err = overrun_reg;
`ifdef PARITY_CHECK_EN
   assign Par_Err     = par_err_reg;
`endif
   assign Busy        = (state_reg != ST_IDLE);

endmodule
